load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory word-address width (1024 words = 4 KB).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port req_valid  input  1  CPU access request.
REQ-006 SHALL have port req_ready  output  1  unit idle and able to accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I size code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  DATA_WIDTH  extended load result.
REQ-013 SHALL have port resp_error  output  1  misaligned access or illegal funct3, qualified by resp_valid.
REQ-014 SHALL have port mem_write  output  1  store enable to the word memory.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  word address to the memory.
REQ-016 SHALL have port mem_wdata  output  DATA_WIDTH  full word to write.
REQ-017 SHALL have port mem_rdata  input  DATA_WIDTH  combinational read data from the memory for mem_addr.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge in IDLE with req_valid=1, and SHALL latch write, funct3, addr and wdata at that edge.
REQ-020 SHALL take word address = latched addr[ADDR_WIDTH+1:2], ignore the upper address bits (silent wrap), and use addr[1:0] as the byte offset.
REQ-021 SHALL flag an error for halfword accesses with addr[0]=1, word accesses with addr[1:0]!=0, and any funct3 not listed in REQ-008; error transitions IDLE->RESP, issues no memory access, and asserts resp_error=1 and resp_rdata=0.
REQ-022 SHALL handle LB/LH/LW/LBU/LHU as IDLE->READ->RESP: in READ, mem_addr = word address, and the selected byte/half is captured, sign- or zero-extended, into resp_rdata at the READ->RESP edge.
REQ-023 SHALL handle SW as IDLE->WRITE->RESP: in WRITE, mem_write=1 for exactly one cycle and mem_wdata = latched wdata.
REQ-024 SHALL handle SB/SH as IDLE->READ->WRITE->RESP (read-modify-write): READ captures mem_rdata; in WRITE, mem_wdata equals the captured word with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0].
REQ-025 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; the earliest next acceptance is the edge ending the first IDLE cycle.
REQ-026 SHALL produce latency from the acceptance edge to the resp_valid cycle of: error 1 cycle; load and SW 2 cycles; SB/SH 3 cycles.
REQ-027 SHALL hold resp_rdata until the next response, and set resp_rdata=0 for stores.
REQ-028 SHALL drive mem_write=0 in every state except WRITE, and mem_addr=0 and mem_wdata=0 in IDLE.
REQ-029 SHALL ignore req_valid and changes on req_* outside IDLE.

Reset
REQ-030 SHALL on rst=1 immediately force state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-031 SHALL abandon any in-flight request when rst is asserted mid-operation, with no memory write issued, including when rst is asserted during WRITE before the edge.

Verification
REQ-032 SHALL be verified by: mem[5]=0x8899AABB, LB addr 0x17 -> mem_addr=5 during READ, resp_rdata=0xFFFFFF88, resp_valid 2 cycles after acceptance.
REQ-033 SHALL be verified by: mem[5]=0x8899AABB, LHU addr 0x14 -> resp_rdata=0x0000AABB, resp_error=0.
REQ-034 SHALL be verified by: mem[2]=0x11223344, SB addr 0x09 wdata 0xFFFFFFAA -> exactly one mem_write pulse with mem_addr=2, mem_wdata=0x1122AA44, resp_valid 3 cycles after acceptance.
REQ-035 SHALL be verified by: SW addr 0x1002 -> resp_error=1 after 1 cycle, mem_write never asserted; SW addr 0x1000 wdata 0xDEADBEEF -> mem_addr=0 (wrap), mem_wdata=0xDEADBEEF.
REQ-036 SHALL be verified by: rst pulsed during the READ cycle of an SH -> no mem_write, req_ready=1 after reset, a following LW completes normally.
REQ-037 SHALL be verified by: back-to-back LW requests with req_valid held high -> acceptances 3 cycles apart, req_ready low while busy.

Source files
------------

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
// ----------------------------------------------------------------------------
// RV32I-style load/store unit in front of a single-port word memory with
// combinational read data. Byte and halfword stores are done as
// read-modify-write on the full word. Misaligned accesses and illegal size
// codes are answered with an error response and never touch the memory.
//
// Ports
//   clk, rst        : single clock, asynchronous active-high reset
//   req_valid/ready : request handshake, ready only while idle
//   req_write       : 1 = store, 0 = load
//   req_funct3      : RV32I size code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr        : byte address, upper bits beyond the memory wrap
//   req_wdata       : right-aligned store data
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : extended load result, held until the next response
//   resp_error      : misaligned access / illegal funct3 (with resp_valid)
//   mem_write       : one-cycle store strobe to the memory
//   mem_addr        : word address to the memory
//   mem_wdata       : full word to write
//   mem_rdata       : combinational read data for mem_addr
// ============================================================================
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Illegal size code for the direction, or an offset that breaks the
    // natural alignment of the access size.
    function automatic logic access_error(input logic       write,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = write;
            F3_HU:   err = write | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Select the addressed byte/half of a memory word and extend it.
    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [2:0]            f3,
                                                          input logic [1:0]            off);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{(DATA_WIDTH-8){b[7]}}, b};
            F3_H:    r = {{(DATA_WIDTH-16){h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {{(DATA_WIDTH-8){1'b0}}, b};
            F3_HU:   r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = {DATA_WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/half of the old word with store data.
    function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [DATA_WIDTH-1:0] wdata,
                                                          input logic [2:0]            f3,
                                                          input logic [1:0]            off);
        logic [DATA_WIDTH-1:0] r;
        r = word;
        case (f3)
            F3_B: begin
                case (off)
                    2'b00:   r[7:0]   = wdata[7:0];
                    2'b01:   r[15:8]  = wdata[7:0];
                    2'b10:   r[23:16] = wdata[7:0];
                    2'b11:   r[31:24] = wdata[7:0];
                    default: r = word;
                endcase
            end
            F3_H: begin
                if (off[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request decode (only consumed at the acceptance edge)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] req_word_s;
    logic                  req_err_s;
    logic                  req_is_sw_s;
    logic                  unused_addr_s;

    // Upper address bits are deliberately dropped: accesses wrap silently.
    assign req_word_s    = req_addr[ADDR_WIDTH+1:2];
    assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];
    assign req_err_s     = access_error(req_write, req_funct3, req_addr[1:0]);
    assign req_is_sw_s   = req_write && (req_funct3 == F3_W);

    // ------------------------------------------------------------------
    // Latched request
    // ------------------------------------------------------------------
    state_t                state_r;
    logic                  write_r;
    logic [2:0]            funct3_r;
    logic [1:0]            off_r;
    logic [DATA_WIDTH-1:0] wdata_r;

    // Control FSM; every output is a register so that reset clears the
    // memory strobe immediately, even in the middle of a WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            write_r    <= 1'b0;
            funct3_r   <= 3'b000;
            off_r      <= 2'b00;
            wdata_r    <= {DATA_WIDTH{1'b0}};
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= {DATA_WIDTH{1'b0}};
            mem_write  <= 1'b0;
            mem_addr   <= {ADDR_WIDTH{1'b0}};
            mem_wdata  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r   <= req_write;
                        funct3_r  <= req_funct3;
                        off_r     <= req_addr[1:0];
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_err_s) begin
                            // Rejected without any memory access.
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= {DATA_WIDTH{1'b0}};
                        end else if (req_is_sw_s) begin
                            // Full-word store needs no read of the old word.
                            state_r   <= ST_WRITE;
                            mem_write <= 1'b1;
                            mem_addr  <= req_word_s;
                            mem_wdata <= req_wdata;
                        end else begin
                            // Loads and SB/SH both read the word first.
                            state_r  <= ST_READ;
                            mem_addr <= req_word_s;
                        end
                    end
                end
                ST_READ: begin
                    if (write_r) begin
                        state_r   <= ST_WRITE;
                        mem_write <= 1'b1;
                        mem_wdata <= store_merge(mem_rdata, wdata_r, funct3_r, off_r);
                    end else begin
                        state_r    <= ST_RESP;
                        mem_addr   <= {ADDR_WIDTH{1'b0}};
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= load_extend(mem_rdata, funct3_r, off_r);
                    end
                end
                ST_WRITE: begin
                    state_r    <= ST_RESP;
                    mem_write  <= 1'b0;
                    mem_addr   <= {ADDR_WIDTH{1'b0}};
                    mem_wdata  <= {DATA_WIDTH{1'b0}};
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= {DATA_WIDTH{1'b0}};
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    mem_write  <= 1'b0;
                    mem_addr   <= {ADDR_WIDTH{1'b0}};
                    mem_wdata  <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit
// ----------------------------------------------------------------------------
// Self-checking bench: a vector table of single requests, each pushing its
// expected response to a scoreboard queue that is popped when resp_valid is
// seen, plus hand-written sequences for reset-in-flight and back-to-back
// acceptance. A behavioural word memory sits on the memory port.
// ============================================================================
module tb_load_store_unit;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the rising edge.
    logic [31:0] mem [0:1023];
    logic        preload = 1'b1;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0000_0000;
            mem[2] <= 32'h1122_3344;
            mem[5] <= 32'h8899_AABB;
            mem[7] <= 32'h7F80_FF01;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [9:0]  exp_maddr;
        int          exp_wr;
        logic [9:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int          checks = 0;
    int          passes = 0;
    int          wr_count = 0;
    logic [9:0]  last_waddr = 10'd0;
    logic [31:0] last_wdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: got no event, required one within the cycle budget", name);
    endtask

    // Advance to the next falling edge and service the monitors there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mem_write) begin
            wr_count++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got resp_valid=1, required 0");
            end else begin
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", 32'(resp_error), 32'(e.err));
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic er,
                                input int lat, input logic [9:0] ma, input int nwr,
                                input logic [9:0] wa, input logic [31:0] wdat);
        vec_t v;
        v.write = w;      v.f3 = f3;          v.addr = a;        v.wdata = wd;
        v.exp_rdata = rd; v.exp_err = er;     v.exp_lat = lat;   v.exp_maddr = ma;
        v.exp_wr = nwr;   v.exp_waddr = wa;   v.exp_wdata = wdat;
        return v;
    endfunction

    // Wait until idle, issue one request, follow it to completion.
    task automatic issue(input int idx, input vec_t v);
        int n;
        int wr0;
        n = 0;
        tick();
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            fail_now($sformatf("v%0d_ready_timeout", idx));
            return;
        end
        req_write  = v.write;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        wr0 = wr_count;
        @(posedge clk);
        #1;
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat, acc: cyc});
        // Scramble the request bus while busy; it must be ignored.
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        tick();
        check($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.exp_maddr));
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            fail_now($sformatf("v%0d_resp_timeout", idx));
            sb_q.delete();
        end
        tick();
        check($sformatf("v%0d_write_pulses", idx), 32'(wr_count - wr0), 32'(v.exp_wr));
        if (v.exp_wr != 0) begin
            check($sformatf("v%0d_write_addr", idx), 32'(last_waddr), 32'(v.exp_waddr));
            check($sformatf("v%0d_write_data", idx), last_wdata, v.exp_wdata);
        end
        check($sformatf("v%0d_rdata_hold", idx), resp_rdata, v.exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   wr0;
        int   n;
        int   acc [2];
        vec_t v;

        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;

        //           w     f3      addr          wdata         rdata         err  lat maddr wr waddr wdata
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0017, 32'h0,        32'hFFFF_FF88, 1'b0, 2, 10'd5, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0014, 32'h0,        32'h0000_AABB, 1'b0, 2, 10'd5, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0016, 32'h0,        32'hFFFF_8899, 1'b0, 2, 10'd5, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0015, 32'h0,        32'h0000_00AA, 1'b0, 2, 10'd5, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0014, 32'h0,        32'h8899_AABB, 1'b0, 2, 10'd5, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0016, 32'h0,        32'h0,         1'b1, 1, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0015, 32'h0,        32'h0,         1'b1, 1, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0014, 32'h0,        32'h0,         1'b1, 1, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0014, 32'h1234,     32'h0,         1'b1, 1, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0009, 32'hFFFF_FFAA, 32'h0,        1'b0, 3, 10'd2, 1, 10'd2, 32'h1122_AA44));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'h1122_AA44, 1'b0, 2, 10'd2, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_000A, 32'h0000_BEEF, 32'h0,        1'b0, 3, 10'd2, 1, 10'd2, 32'hBEEF_AA44));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'hBEEF_AA44, 1'b0, 2, 10'd2, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_1002, 32'hDEAD_BEEF, 32'h0,        1'b1, 1, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 10'd0, 1, 10'd0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_001C, 32'h0,        32'h0000_0001, 1'b0, 2, 10'd7, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_001D, 32'h0,        32'hFFFF_FFFF, 1'b0, 2, 10'd7, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_001E, 32'h0,        32'h0000_7F80, 1'b0, 2, 10'd7, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0009, 32'h5555,     32'h0,         1'b1, 1, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0017, 32'h0,        32'h0,         1'b1, 1, 10'd0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_1014, 32'h0,        32'h8899_AABB, 1'b0, 2, 10'd5, 0, 10'd0, 32'h0));

        // Asynchronous reset takes effect without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'h0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) issue(i, vecs[i]);

        // Reset during the READ cycle of an SH: no write, word unchanged.
        issue(100, mk(1'b0, 3'b010, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0, 2, 10'd2, 0, 10'd0, 32'h0));
        tick();
        req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'hA; req_wdata = 32'h1234;
        req_valid = 1'b1;
        wr0 = wr_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("sh_busy_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("sh_rst_ready",     32'(req_ready), 32'd1);
        check("sh_rst_mem_write", 32'(mem_write), 32'd0);
        check("sh_rst_rdata",     resp_rdata,     32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("sh_rst_pulses", 32'(wr_count - wr0), 32'd0);
        check("sh_rst_mem2",   mem[2],              32'hBEEF_AA44);

        // Reset while mem_write is already high in WRITE: strobe drops at once.
        req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8; req_wdata = 32'h55;
        req_valid = 1'b1;
        wr0 = wr_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sb_in_write", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("sb_rst_mem_write", 32'(mem_write), 32'd0);
        check("sb_rst_ready",     32'(req_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("sb_rst_pulses", 32'(wr_count - wr0), 32'd0);
        check("sb_rst_mem2",   mem[2],              32'hBEEF_AA44);
        issue(101, mk(1'b0, 3'b010, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0, 2, 10'd2, 0, 10'd0, 32'h0));

        // Back-to-back LW with req_valid held high.
        tick();
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'h0;
        req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!req_ready && n < 20) begin
                tick();
                n++;
            end
            if (!req_ready) fail_now("b2b_ready_timeout");
            @(posedge clk);
            #1;
            sb_q.push_back('{rdata: 32'h8899_AABB, err: 1'b0, lat: 2, acc: cyc});
            acc[k] = cyc;
            tick();
            check("b2b_busy_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            fail_now("b2b_resp_timeout");
            sb_q.delete();
        end
        check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd3);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
